// File: rtl/alu_ctrl_seq.sv
// ALU control decoder for RV32I with an RV32M handshake sequencer that starts an external
// iterative multiply/divide unit and stalls the core until it completes or times out.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned EN_M        = 1,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic              opb5,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic [1:0]        ALUOp,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              illegal,
  output logic              mdu_start,
  output logic [2:0]        mdu_op,
  input  logic              mdu_done,
  output logic              mdu_err,
  output logic              stall
);

  localparam bit          MEn  = (EN_M != 0);
  localparam int unsigned CntW = $clog2(MDU_TIMEOUT + 1);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpSltu = 4'b0110;
  localparam logic [3:0] OpSll  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1001;
  localparam logic [3:0] OpMdu  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic [2:0]        mdu_op_q, mdu_op_d;
  logic              mdu_start_q, mdu_start_d;
  logic              mdu_err_q, mdu_err_d;
  logic              is_m;
  logic              start_req;
  logic [3:0]        code;

  assign is_m      = (ALUOp == 2'b10) & opb5 & funct7b0;
  assign start_req = MEn & valid_i & is_m;

  always_comb begin
    code    = OpAdd;
    illegal = 1'b0;
    case (ALUOp)
      2'b00: code = OpAdd;
      2'b01: code = OpSub;
      2'b11: begin
        code    = OpAdd;
        illegal = valid_i;
      end
      default: begin
        if (is_m) begin
          if (MEn) begin
            code = OpMdu;
          end else begin
            code    = OpAdd;
            illegal = valid_i;
          end
        end else begin
          unique case (funct3)
            3'b000:  code = (funct7b5 & opb5) ? OpSub : OpAdd;
            3'b001:  code = OpSll;
            3'b010:  code = OpSlt;
            3'b011:  code = OpSltu;
            3'b100:  code = OpXor;
            3'b101:  code = funct7b5 ? OpSra : OpSrl;  // srai/srli share funct7b5 with R-type
            3'b110:  code = OpOr;
            default: code = OpAnd;
          endcase
        end
      end
    endcase
  end

  assign ALUControl = CTRL_W'(code);

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_op_d    = mdu_op_q;
    mdu_start_d = 1'b0;
    mdu_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d     = StBusy;
          mdu_op_d    = funct3;
          cnt_d       = '0;
          mdu_start_d = 1'b1;
        end
      end
      StBusy: begin
        cnt_d = cnt_inc;
        // mdu_start_q marks the first BUSY cycle, where a stale done is ignored
        if (!mdu_start_q && mdu_done) begin
          state_d = StDone;
        end else if (cnt_inc == CntW'(MDU_TIMEOUT)) begin
          state_d   = StDone;
          mdu_err_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mdu_op_q    <= 3'b000;
      mdu_start_q <= 1'b0;
      mdu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_op_q    <= mdu_op_d;
      mdu_start_q <= mdu_start_d;
      mdu_err_q   <= mdu_err_d;
    end
  end

  assign mdu_start = mdu_start_q;
  assign mdu_err   = mdu_err_q;
  assign mdu_op    = mdu_op_q;
  assign stall     = ((state_q == StIdle) & start_req) | (state_q == StBusy);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: one M-enabled instance (MDU_TIMEOUT=8, widened code) and one
// M-disabled instance share the same stimulus.
module tb_alu_ctrl_seq;
  localparam int unsigned Timeout = 8;

  logic       clk = 1'b0;
  logic       reset_n, valid_i, opb5, funct7b5, funct7b0, mdu_done;
  logic [2:0] funct3;
  logic [1:0] alu_op;

  logic [5:0] ctrl;
  logic       illegal, mdu_start, mdu_err, stall;
  logic [2:0] mdu_op;
  logic [3:0] ctrl_nm;
  logic       illegal_nm, mdu_start_nm, mdu_err_nm, stall_nm;
  logic [2:0] mdu_op_nm;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [2:0]  prev_op = 3'b000;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.CTRL_W(6), .EN_M(1), .MDU_TIMEOUT(Timeout)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .opb5(opb5), .funct3(funct3),
    .funct7b5(funct7b5), .funct7b0(funct7b0), .ALUOp(alu_op), .ALUControl(ctrl),
    .illegal(illegal), .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_done(mdu_done),
    .mdu_err(mdu_err), .stall(stall)
  );

  alu_ctrl_seq #(.CTRL_W(4), .EN_M(0), .MDU_TIMEOUT(Timeout)) dut_nm (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .opb5(opb5), .funct3(funct3),
    .funct7b5(funct7b5), .funct7b0(funct7b0), .ALUOp(alu_op), .ALUControl(ctrl_nm),
    .illegal(illegal_nm), .mdu_start(mdu_start_nm), .mdu_op(mdu_op_nm), .mdu_done(mdu_done),
    .mdu_err(mdu_err_nm), .stall(stall_nm)
  );

  // Operation table straight from the encoding list.
  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f7b5, input logic ob5, input logic f7b0,
                                          input bit en_m);
    if (op == 2'd0) return 4'd0;
    if (op == 2'd1) return 4'd1;
    if (op == 2'd3) return 4'd0;
    if (ob5 && f7b0) return en_m ? 4'd15 : 4'd0;
    case (f3)
      3'd0: return (f7b5 && ob5) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7b5 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic v, input logic [1:0] op, input logic ob5,
                                       input logic f7b0, input bit en_m);
    return v && (op == 2'd3 || (op == 2'd2 && ob5 && f7b0 && !en_m));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; alu_op = 2'b00; funct3 = 3'b000; opb5 = 1'b0;
    funct7b5 = 1'b0; funct7b0 = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    #2;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_total++; if (mdu_start !== 1'b0) $display("FAIL reset_start got=%b exp=0", mdu_start); else n_pass++;
    n_total++; if (mdu_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", mdu_err); else n_pass++;
    n_total++; if (mdu_op !== 3'b000) $display("FAIL reset_op got=%b exp=000", mdu_op); else n_pass++;
    reset_n = 1'b1;
    next_cycle();
    #2;
    n_total++; if (mdu_start !== 1'b0) $display("FAIL post_reset_start got=%b exp=0", mdu_start); else n_pass++;
    next_cycle();
  endtask

  task automatic test_decode_sweep();
    logic [3:0] e;
    valid_i = 1'b1; alu_op = 2'b10; funct7b0 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      funct3 = i[2:0]; funct7b5 = i[3]; opb5 = i[4];
      #1;
      e = ref_code(alu_op, funct3, funct7b5, opb5, funct7b0, 1'b1);
      n_total++; if (ctrl !== 6'(e)) $display("FAIL sweep_ctrl f3=%0d f7b5=%b opb5=%b got=%b exp=%b", funct3, funct7b5, opb5, ctrl, 6'(e)); else n_pass++;
      n_total++; if (illegal !== 1'b0) $display("FAIL sweep_illegal f3=%0d got=%b exp=0", funct3, illegal); else n_pass++;
    end
    for (int op = 0; op < 4; op++) begin
      if (op == 2) continue;
      for (int v = 0; v < 2; v++) begin
        alu_op = op[1:0]; valid_i = v[0];
        #1;
        e = ref_code(alu_op, funct3, funct7b5, opb5, funct7b0, 1'b1);
        n_total++; if (ctrl !== 6'(e)) $display("FAIL aluop_ctrl op=%0d got=%b exp=%b", op, ctrl, 6'(e)); else n_pass++;
        n_total++; if (illegal !== ref_illegal(valid_i, alu_op, opb5, funct7b0, 1'b1)) $display("FAIL aluop_illegal op=%0d v=%0d got=%b", op, v, illegal); else n_pass++;
      end
    end
    idle_inputs();
    next_cycle();
  endtask

  // Random encodings with valid low: decode must still be produced, nothing may start.
  task automatic test_decode_random();
    logic [3:0] e, e_nm;
    for (int i = 0; i < 40; i++) begin
      valid_i = 1'b0; alu_op = 2'($urandom); funct3 = 3'($urandom); opb5 = 1'($urandom);
      funct7b5 = 1'($urandom); funct7b0 = 1'($urandom);
      #1;
      e    = ref_code(alu_op, funct3, funct7b5, opb5, funct7b0, 1'b1);
      e_nm = ref_code(alu_op, funct3, funct7b5, opb5, funct7b0, 1'b0);
      n_total++; if (ctrl !== 6'(e)) $display("FAIL rand_ctrl got=%b exp=%b", ctrl, 6'(e)); else n_pass++;
      n_total++; if (ctrl_nm !== e_nm) $display("FAIL rand_ctrl_nm got=%b exp=%b", ctrl_nm, e_nm); else n_pass++;
      n_total++; if ((illegal | illegal_nm) !== 1'b0) $display("FAIL rand_illegal got=%b/%b exp=0", illegal, illegal_nm); else n_pass++;
      n_total++; if (stall !== 1'b0) $display("FAIL rand_stall got=%b exp=0", stall); else n_pass++;
    end
    idle_inputs();
    next_cycle();
  endtask

  // Present one M op held valid through DONE; done pulses on BUSY cycle done_at (0 = never).
  task automatic run_m_op(input logic [2:0] f3, input int done_at);
    int  busy_len;
    bit  exp_err;
    logic [2:0] exp_op;
    exp_err  = !(done_at >= 2 && done_at <= int'(Timeout));
    busy_len = exp_err ? int'(Timeout) : done_at;
    for (int k = 0; k <= busy_len + 1; k++) begin
      valid_i = 1'b1; alu_op = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct7b5 = 1'b0;
      funct3 = f3; mdu_done = (k >= 1 && k == done_at);
      #2;
      exp_op = (k == 0) ? prev_op : f3;
      n_total++; if (stall !== (k <= busy_len)) $display("FAIL m_stall f3=%0d k=%0d got=%b", f3, k, stall); else n_pass++;
      n_total++; if (mdu_start !== (k == 1)) $display("FAIL m_start f3=%0d k=%0d got=%b", f3, k, mdu_start); else n_pass++;
      n_total++; if (mdu_err !== (exp_err && k == busy_len + 1)) $display("FAIL m_err f3=%0d k=%0d got=%b", f3, k, mdu_err); else n_pass++;
      n_total++; if (mdu_op !== exp_op) $display("FAIL m_op k=%0d got=%b exp=%b", k, mdu_op, exp_op); else n_pass++;
      n_total++; if ({illegal, ctrl} !== 7'b0_001111) $display("FAIL m_decode k=%0d got=%b/%b", k, illegal, ctrl); else n_pass++;
      n_total++; if ({illegal_nm, ctrl_nm} !== 5'b1_0000) $display("FAIL nm_decode got=%b/%b exp=1/0000", illegal_nm, ctrl_nm); else n_pass++;
      n_total++; if ({stall_nm, mdu_start_nm, mdu_err_nm, mdu_op_nm} !== 6'b0) $display("FAIL nm_fsm got=%b%b%b%b exp=0", stall_nm, mdu_start_nm, mdu_err_nm, mdu_op_nm); else n_pass++;
      next_cycle();
    end
    prev_op  = f3;
    mdu_done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    idle_inputs();
    #2;
    n_total++; if (stall !== 1'b0) $display("FAIL %s_stall got=%b exp=0", tag, stall); else n_pass++;
    n_total++; if (mdu_start !== 1'b0) $display("FAIL %s_start got=%b exp=0", tag, mdu_start); else n_pass++;
    n_total++; if (mdu_err !== 1'b0) $display("FAIL %s_err got=%b exp=0", tag, mdu_err); else n_pass++;
    n_total++; if (mdu_op !== prev_op) $display("FAIL %s_op got=%b exp=%b", tag, mdu_op, prev_op); else n_pass++;
    next_cycle();
  endtask

  task automatic test_mul();
    run_m_op(3'b000, 3);
    check_idle("mul_idle");
  endtask

  task automatic test_timeout();
    run_m_op(3'b100, 0);
    check_idle("tmo_idle");
    run_m_op(3'b100, int'(Timeout));
    check_idle("tmo_done_idle");
  endtask

  task automatic test_back_to_back();
    run_m_op(3'b000, 2);
    run_m_op(3'b110, 4);
    check_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_busy();
    run_m_op(3'b101, 2);
    valid_i = 1'b1; alu_op = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct3 = 3'b011;
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
    idle_inputs();
    #2;
    n_total++; if (stall !== 1'b1) $display("FAIL rst_busy_stall got=%b exp=1", stall); else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    prev_op = 3'b000;
    for (int k = 0; k < 3; k++) check_idle("rst_mid");
  endtask

  task automatic test_random_m();
    for (int i = 0; i < 12; i++) begin
      run_m_op(3'($urandom), int'($urandom_range(0, 11)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) check_idle("rand_gap");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode_sweep();
    test_decode_random();
    test_mul();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_m();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
